// File: rtl/quadrature_nco_mc_if.sv
// rtl/quadrature_nco_mc_if.sv - tuning handshake and sample bus of the multi-channel NCO
//
// Purpose: bundles the sample-rate control, tuning write handshake and sample
// outputs of quadrature_nco_mc.
// Signals:
//   sample_clk_ce  sample-rate clock enable
//   phase_sync     zero all accumulators (qualified by sample_clk_ce)
//   cfg_valid      tuning write request
//   cfg_ready      tuning write can be accepted
//   cfg_channel    target channel of the tuning write
//   cfg_increment  new phase increment
//   cfg_offset     new phase offset in table steps
//   out_valid      one-cycle strobe: new samples on sinewave/cosinewave
//   sinewave       packed signed sine, channel k at [k*SINE_WIDTH +: SINE_WIDTH]
//   cosinewave     packed signed cosine, same packing
// Modports: master drives control/tuning, slave is the NCO.
interface quadrature_nco_mc_if #(
  parameter int SINE_WIDTH   = 7,
  parameter int LUT_WIDTH    = 8,
  parameter int PHASE_WIDTH  = 64,
  parameter int NUM_CHANNELS = 2,
  parameter int CH_W         = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) ();
  logic                                 sample_clk_ce;
  logic                                 phase_sync;
  logic                                 cfg_valid;
  logic                                 cfg_ready;
  logic [CH_W-1:0]                      cfg_channel;
  logic [PHASE_WIDTH-1:0]               cfg_increment;
  logic [LUT_WIDTH-1:0]                 cfg_offset;
  logic                                 out_valid;
  logic [NUM_CHANNELS*SINE_WIDTH-1:0]   sinewave;
  logic [NUM_CHANNELS*SINE_WIDTH-1:0]   cosinewave;

  modport master (
    output sample_clk_ce, phase_sync, cfg_valid, cfg_channel, cfg_increment, cfg_offset,
    input  cfg_ready, out_valid, sinewave, cosinewave
  );

  modport slave (
    input  sample_clk_ce, phase_sync, cfg_valid, cfg_channel, cfg_increment, cfg_offset,
    output cfg_ready, out_valid, sinewave, cosinewave
  );
endinterface

// File: rtl/quadrature_nco_mc.sv
// rtl/quadrature_nco_mc.sv - multi-channel quadrature NCO with shared quarter-wave table
//
// Purpose: NUM_CHANNELS independent phase accumulators, each with its own
// increment and phase offset, share one quarter-wave sine table. Tuning writes
// go through a single shadow register and are committed on a sample boundary
// so a retune never produces a half-updated sample. Samples appear two cycles
// after each sample_clk_ce, qualified by a one-cycle out_valid strobe.
// Ports:
//   clk   clock
//   arst  asynchronous active-high reset
//   bus   quadrature_nco_mc_if slave modport (ce, phase_sync, cfg handshake,
//         out_valid, packed sine/cosine outputs)
module quadrature_nco_mc #(
  parameter int SINE_WIDTH   = 7,
  parameter int LUT_WIDTH    = 8,
  parameter int PHASE_WIDTH  = 64,
  parameter int NUM_CHANNELS = 2,
  parameter int CH_W         = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                   clk,
  input  logic                   arst,
  quadrature_nco_mc_if.slave     bus
);

  localparam int N   = 1 << LUT_WIDTH;
  localparam int QN  = N / 4;
  localparam int IW  = LUT_WIDTH - 2;
  localparam int MW  = SINE_WIDTH - 1;
  localparam int AMP = (1 << (SINE_WIDTH - 1)) - 1;

  // Elaboration-time table entry: round(AMP*sin(pi*(2k+1)/N)) evaluated with an
  // integer Taylor series in Q30 so no real-number support is needed.
  function automatic longint quarter_sine(input int k);
    longint x;
    longint x2;
    longint term;
    longint sum;
    x    = (64'sd3373259426 * longint'(2 * k + 1)) / longint'(N);
    x2   = (x * x) >>> 30;
    term = x;
    sum  = x;
    for (int n = 1; n <= 9; n++) begin
      term = -((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    return (longint'(AMP) * sum + (64'sd1 <<< 29)) >>> 30;
  endfunction

  logic [MW-1:0] w_lut [QN];

  for (genvar gk = 0; gk < QN; gk++) begin : g_lut
    localparam logic [MW-1:0] QV = MW'(quarter_sine(gk));
    assign w_lut[gk] = QV;
  end

  // Tuning state
  logic [PHASE_WIDTH-1:0] r_acc    [NUM_CHANNELS];
  logic [PHASE_WIDTH-1:0] r_inc    [NUM_CHANNELS];
  logic [LUT_WIDTH-1:0]   r_off    [NUM_CHANNELS];
  logic                   r_pending;
  logic [CH_W-1:0]        r_sh_ch;
  logic [PHASE_WIDTH-1:0] r_sh_inc;
  logic [LUT_WIDTH-1:0]   r_sh_off;

  // Pipeline state
  logic [LUT_WIDTH-1:0]   r_addr   [NUM_CHANNELS];
  logic                   r_s1_valid;
  logic                   r_out_valid;
  logic [NUM_CHANNELS*SINE_WIDTH-1:0] r_sine;
  logic [NUM_CHANNELS*SINE_WIDTH-1:0] r_cosine;

  logic                   w_accept;
  logic [1:0]             w_cos_quad [NUM_CHANNELS];
  logic [IW-1:0]          w_sin_idx  [NUM_CHANNELS];
  logic [IW-1:0]          w_cos_idx  [NUM_CHANNELS];
  logic [SINE_WIDTH-1:0]  w_sin_mag  [NUM_CHANNELS];
  logic [SINE_WIDTH-1:0]  w_cos_mag  [NUM_CHANNELS];
  logic [SINE_WIDTH-1:0]  w_sin_val  [NUM_CHANNELS];
  logic [SINE_WIDTH-1:0]  w_cos_val  [NUM_CHANNELS];

  // Only one write can sit in the shadow register; a second waits for commit.
  assign w_accept      = bus.cfg_valid & ~r_pending;
  assign bus.cfg_ready = ~r_pending;
  assign bus.out_valid = r_out_valid;
  assign bus.sinewave  = r_sine;
  assign bus.cosinewave = r_cosine;

  // Quadrant folding: odd quadrants read the table mirrored (~i == QN-1-i),
  // the upper half-period negates. Cosine is the sine one quadrant ahead.
  always_comb begin
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      w_cos_quad[k] = r_addr[k][LUT_WIDTH-1 -: 2] + 2'd1;
      w_sin_idx[k]  = r_addr[k][LUT_WIDTH-2] ? ~r_addr[k][IW-1:0] : r_addr[k][IW-1:0];
      w_cos_idx[k]  = w_cos_quad[k][0]       ? ~r_addr[k][IW-1:0] : r_addr[k][IW-1:0];
      w_sin_mag[k]  = {1'b0, w_lut[w_sin_idx[k]]};
      w_cos_mag[k]  = {1'b0, w_lut[w_cos_idx[k]]};
      w_sin_val[k]  = r_addr[k][LUT_WIDTH-1] ? -w_sin_mag[k] : w_sin_mag[k];
      w_cos_val[k]  = w_cos_quad[k][1]       ? -w_cos_mag[k] : w_cos_mag[k];
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int k = 0; k < NUM_CHANNELS; k++) begin
        r_acc[k]  <= '0;
        r_inc[k]  <= '0;
        r_off[k]  <= '0;
        r_addr[k] <= '0;
      end
      r_pending   <= 1'b0;
      r_sh_ch     <= '0;
      r_sh_inc    <= '0;
      r_sh_off    <= '0;
      r_s1_valid  <= 1'b0;
      r_out_valid <= 1'b0;
      r_sine      <= '0;
      r_cosine    <= '0;
    end else begin
      r_s1_valid  <= bus.sample_clk_ce;
      r_out_valid <= r_s1_valid;

      // Stage 1 and accumulator update both see pre-update acc/inc/offset, so a
      // commit on this edge only influences the following sample.
      if (bus.sample_clk_ce) begin
        for (int k = 0; k < NUM_CHANNELS; k++) begin
          r_addr[k] <= r_acc[k][PHASE_WIDTH-1 -: LUT_WIDTH] + r_off[k];
          r_acc[k]  <= bus.phase_sync ? '0 : r_acc[k] + r_inc[k];
        end
      end

      // Accept and commit are mutually exclusive (accept needs !pending), so a
      // write accepted on a ce edge always waits for the next ce to commit.
      // Out-of-range channels match no k and are dropped at commit.
      if (bus.sample_clk_ce && r_pending) begin
        r_pending <= 1'b0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
          if (int'(r_sh_ch) == k) begin
            r_inc[k] <= r_sh_inc;
            r_off[k] <= r_sh_off;
          end
        end
      end else if (w_accept) begin
        r_pending <= 1'b1;
        r_sh_ch   <= bus.cfg_channel;
        r_sh_inc  <= bus.cfg_increment;
        r_sh_off  <= bus.cfg_offset;
      end

      // Stage 2: outputs hold between strobes.
      if (r_s1_valid) begin
        for (int k = 0; k < NUM_CHANNELS; k++) begin
          r_sine[k*SINE_WIDTH +: SINE_WIDTH]   <= w_sin_val[k];
          r_cosine[k*SINE_WIDTH +: SINE_WIDTH] <= w_cos_val[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_quadrature_nco_mc.sv
// tb/tb_quadrature_nco_mc.sv - directed vector bench for quadrature_nco_mc
module tb_quadrature_nco_mc;
  localparam int SW = 7;
  localparam int LW = 8;
  localparam int PW = 64;
  localparam int NC = 3;
  localparam int CW = 2;
  localparam int NV = 48;

  localparam logic [63:0] I64  = 64'h4000_0000_0000_0000;
  localparam logic [63:0] I128 = 64'h8000_0000_0000_0000;
  localparam logic [63:0] IM1  = 64'hFF00_0000_0000_0000;

  typedef struct {
    bit          ce;
    bit          sy;
    bit          cv;
    int          ch;
    logic [63:0] inc;
    int          off;
    int          rdy;
    int          vld;
    int          s0, c0, s1, c1, s2, c2;
  } vec_t;

  logic clk = 1'b0;
  logic arst;
  int   n_pass = 0;
  int   n_total = 0;
  vec_t v [NV];

  quadrature_nco_mc_if #(.SINE_WIDTH(SW), .LUT_WIDTH(LW), .PHASE_WIDTH(PW), .NUM_CHANNELS(NC)) nco_bus ();

  quadrature_nco_mc #(.SINE_WIDTH(SW), .LUT_WIDTH(LW), .PHASE_WIDTH(PW), .NUM_CHANNELS(NC)) dut (
    .clk  (clk),
    .arst (arst),
    .bus  (nco_bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(bit ce, bit sy, bit cv, int ch, logic [63:0] inc, int off,
                              int rdy, int vld, int s0, int c0, int s1, int c1, int s2, int c2);
    vec_t t;
    t.ce = ce; t.sy = sy; t.cv = cv; t.ch = ch; t.inc = inc; t.off = off;
    t.rdy = rdy; t.vld = vld;
    t.s0 = s0; t.c0 = c0; t.s1 = s1; t.c1 = c1; t.s2 = s2; t.c2 = c2;
    return t;
  endfunction

  function automatic int sin_of(int k);
    logic signed [SW-1:0] x;
    x = nco_bus.sinewave[k*SW +: SW];
    return int'(x);
  endfunction

  function automatic int cos_of(int k);
    logic signed [SW-1:0] x;
    x = nco_bus.cosinewave[k*SW +: SW];
    return int'(x);
  endfunction

  task automatic check(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  task automatic drive(bit ce, bit sy, bit cv, int ch, logic [63:0] inc, int off);
    nco_bus.sample_clk_ce = ce;
    nco_bus.phase_sync    = sy;
    nco_bus.cfg_valid     = cv;
    nco_bus.cfg_channel   = CW'(ch);
    nco_bus.cfg_increment = inc;
    nco_bus.cfg_offset    = LW'(off);
  endtask

  initial begin
    // Each row: inputs for that cycle, expected outputs seen in that cycle.
    //          ce sy cv ch inc   off rdy vld  s0  c0  s1  c1 s2 c2
    v[0]  = mk(1, 0, 0, 0, 0,    0,  1, 0,   0,  0,  0,  0, 0, 0);
    v[1]  = mk(1, 0, 0, 0, 0,    0,  1, 0,   0,  0,  0,  0, 0, 0);
    v[2]  = mk(1, 0, 0, 0, 0,    0,  1, 1,   1, 63,  1, 63, 1, 63);
    v[3]  = mk(0, 0, 1, 0, I64,  0,  1, 1,   1, 63,  1, 63, 1, 63);
    v[4]  = mk(0, 0, 0, 0, 0,    0,  0, 1,   1, 63,  1, 63, 1, 63);
    v[5]  = mk(1, 0, 0, 0, 0,    0,  0, 0,   1, 63,  1, 63, 1, 63);
    v[6]  = mk(1, 0, 0, 0, 0,    0,  1, 0,   1, 63,  1, 63, 1, 63);
    v[7]  = mk(1, 0, 0, 0, 0,    0,  1, 1,   1, 63,  1, 63, 1, 63);
    v[8]  = mk(1, 0, 0, 0, 0,    0,  1, 1,   1, 63,  1, 63, 1, 63);
    v[9]  = mk(1, 0, 0, 0, 0,    0,  1, 1,  63, -1,  1, 63, 1, 63);
    v[10] = mk(1, 0, 0, 0, 0,    0,  1, 1,  -1, -63, 1, 63, 1, 63);
    v[11] = mk(1, 0, 0, 0, 0,    0,  1, 1, -63,  1,  1, 63, 1, 63);
    v[12] = mk(0, 0, 0, 0, 0,    0,  1, 1,   1, 63,  1, 63, 1, 63);
    v[13] = mk(0, 0, 0, 0, 0,    0,  1, 1,  63, -1,  1, 63, 1, 63);
    v[14] = mk(0, 0, 0, 0, 0,    0,  1, 0,  63, -1,  1, 63, 1, 63);
    v[15] = mk(0, 0, 1, 1, 0,   64,  1, 0,  63, -1,  1, 63, 1, 63);
    v[16] = mk(1, 0, 0, 0, 0,    0,  0, 0,  63, -1,  1, 63, 1, 63);
    v[17] = mk(1, 0, 0, 0, 0,    0,  1, 0,  63, -1,  1, 63, 1, 63);
    v[18] = mk(0, 0, 0, 0, 0,    0,  1, 1,  -1, -63, 1, 63, 1, 63);
    v[19] = mk(0, 0, 0, 0, 0,    0,  1, 1, -63,  1, 63, -1, 1, 63);
    v[20] = mk(0, 0, 0, 0, 0,    0,  1, 0, -63,  1, 63, -1, 1, 63);
    v[21] = mk(0, 0, 1, 3, I128, 32, 1, 0, -63,  1, 63, -1, 1, 63);
    v[22] = mk(0, 0, 1, 0, 0,    0,  0, 0, -63,  1, 63, -1, 1, 63);
    v[23] = mk(1, 0, 1, 0, 0,    0,  0, 0, -63,  1, 63, -1, 1, 63);
    v[24] = mk(0, 0, 1, 0, 0,    0,  1, 0, -63,  1, 63, -1, 1, 63);
    v[25] = mk(0, 0, 0, 0, 0,    0,  0, 1,   1, 63, 63, -1, 1, 63);
    v[26] = mk(1, 0, 0, 0, 0,    0,  0, 0,   1, 63, 63, -1, 1, 63);
    v[27] = mk(1, 0, 0, 0, 0,    0,  1, 0,   1, 63, 63, -1, 1, 63);
    v[28] = mk(1, 0, 0, 0, 0,    0,  1, 1,  63, -1, 63, -1, 1, 63);
    v[29] = mk(0, 0, 0, 0, 0,    0,  1, 1,  -1, -63, 63, -1, 1, 63);
    v[30] = mk(0, 0, 0, 0, 0,    0,  1, 1,  -1, -63, 63, -1, 1, 63);
    v[31] = mk(0, 0, 0, 0, 0,    0,  1, 0,  -1, -63, 63, -1, 1, 63);
    v[32] = mk(0, 0, 1, 0, IM1,  0,  1, 0,  -1, -63, 63, -1, 1, 63);
    v[33] = mk(1, 1, 0, 0, 0,    0,  0, 0,  -1, -63, 63, -1, 1, 63);
    v[34] = mk(1, 0, 0, 0, 0,    0,  1, 0,  -1, -63, 63, -1, 1, 63);
    v[35] = mk(1, 0, 0, 0, 0,    0,  1, 1,  -1, -63, 63, -1, 1, 63);
    v[36] = mk(1, 0, 0, 0, 0,    0,  1, 1,   1, 63, 63, -1, 1, 63);
    v[37] = mk(0, 0, 0, 0, 0,    0,  1, 1,  -1, 63, 63, -1, 1, 63);
    v[38] = mk(0, 0, 0, 0, 0,    0,  1, 1,  -2, 63, 63, -1, 1, 63);
    v[39] = mk(0, 0, 0, 0, 0,    0,  1, 0,  -2, 63, 63, -1, 1, 63);
    v[40] = mk(1, 1, 0, 0, 0,    0,  1, 0,  -2, 63, 63, -1, 1, 63);
    v[41] = mk(1, 0, 0, 0, 0,    0,  1, 0,  -2, 63, 63, -1, 1, 63);
    v[42] = mk(0, 0, 0, 0, 0,    0,  1, 1,  -4, 63, 63, -1, 1, 63);
    v[43] = mk(0, 0, 0, 0, 0,    0,  1, 1,   1, 63, 63, -1, 1, 63);
    v[44] = mk(0, 1, 0, 0, 0,    0,  1, 0,   1, 63, 63, -1, 1, 63);
    v[45] = mk(1, 0, 0, 0, 0,    0,  1, 0,   1, 63, 63, -1, 1, 63);
    v[46] = mk(0, 0, 0, 0, 0,    0,  1, 0,   1, 63, 63, -1, 1, 63);
    v[47] = mk(0, 0, 0, 0, 0,    0,  1, 1,  -1, 63, 63, -1, 1, 63);

    arst = 1'b1;
    drive(0, 0, 0, 0, '0, 0);
    repeat (3) @(negedge clk);
    check("reset rdy", int'(nco_bus.cfg_ready), 1);
    check("reset vld", int'(nco_bus.out_valid), 0);
    check("reset sin0", sin_of(0), 0);
    check("reset cos0", cos_of(0), 0);
    arst = 1'b0;

    for (int r = 0; r < NV; r++) begin
      @(negedge clk);
      check($sformatf("r%0d rdy", r), int'(nco_bus.cfg_ready), v[r].rdy);
      check($sformatf("r%0d vld", r), int'(nco_bus.out_valid), v[r].vld);
      check($sformatf("r%0d sin0", r), sin_of(0), v[r].s0);
      check($sformatf("r%0d cos0", r), cos_of(0), v[r].c0);
      check($sformatf("r%0d sin1", r), sin_of(1), v[r].s1);
      check($sformatf("r%0d cos1", r), cos_of(1), v[r].c1);
      check($sformatf("r%0d sin2", r), sin_of(2), v[r].s2);
      check($sformatf("r%0d cos2", r), cos_of(2), v[r].c2);
      drive(v[r].ce, v[r].sy, v[r].cv, v[r].ch, v[r].inc, v[r].off);
    end

    // Reset while a tuning write is pending: write must be discarded.
    @(negedge clk);
    drive(0, 0, 1, 0, I64, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, '0, 0);
    check("pend rdy", int'(nco_bus.cfg_ready), 0);
    #2 arst = 1'b1;
    #1;
    check("arst rdy", int'(nco_bus.cfg_ready), 1);
    check("arst vld", int'(nco_bus.out_valid), 0);
    check("arst sin0", sin_of(0), 0);
    check("arst cos1", cos_of(1), 0);
    drive(1, 0, 0, 0, '0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("in_arst%0d vld", i), int'(nco_bus.out_valid), 0);
      check($sformatf("in_arst%0d sin0", i), sin_of(0), 0);
      check($sformatf("in_arst%0d cos0", i), cos_of(0), 0);
    end
    arst = 1'b0;
    @(negedge clk);
    check("post_arst vld0", int'(nco_bus.out_valid), 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("post_arst%0d vld", i), int'(nco_bus.out_valid), 1);
      check($sformatf("post_arst%0d sin0", i), sin_of(0), 1);
      check($sformatf("post_arst%0d cos0", i), cos_of(0), 63);
      check($sformatf("post_arst%0d rdy", i), int'(nco_bus.cfg_ready), 1);
    end
    drive(0, 0, 0, 0, '0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
